// File: rtl/tl_tx_arb.sv
// Transaction-layer TX scheduler: round-robin arbiter over P/NP/CPL with
// credit-gated eligibility, one packet in flight, registered consume pulses.
module tl_tx_arb #(
  parameter int DATA_W     = 64,
  parameter int PH_WIDTH   = 8,
  parameter int PD_WIDTH   = 12,
  parameter int NPH_WIDTH  = 8,
  parameter int NPD_WIDTH  = 12,
  parameter int CPLH_WIDTH = 8,
  parameter int CPLD_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  p_req_v_i,
  input  logic                  np_req_v_i,
  input  logic                  cpl_req_v_i,

  input  logic [PH_WIDTH-1:0]   p_hdr_cr_i,
  input  logic [PD_WIDTH-1:0]   p_data_cr_i,
  input  logic [NPH_WIDTH-1:0]  np_hdr_cr_i,
  input  logic [NPD_WIDTH-1:0]  np_data_cr_i,
  input  logic [CPLH_WIDTH-1:0] cpl_hdr_cr_i,
  input  logic [CPLD_WIDTH-1:0] cpl_data_cr_i,

  input  logic [DATA_W-1:0]     p_data_i,
  input  logic [DATA_W-1:0]     np_data_i,
  input  logic [DATA_W-1:0]     cpl_data_i,
  input  logic                  p_valid_i,
  input  logic                  np_valid_i,
  input  logic                  cpl_valid_i,
  input  logic                  p_last_i,
  input  logic                  np_last_i,
  input  logic                  cpl_last_i,
  output logic                  p_ready_o,
  output logic                  np_ready_o,
  output logic                  cpl_ready_o,

  input  logic                  ph_credit_ok_i,
  input  logic                  pd_credit_ok_i,
  input  logic                  nph_credit_ok_i,
  input  logic                  npd_credit_ok_i,
  input  logic                  cplh_credit_ok_i,
  input  logic                  cpld_credit_ok_i,

  output logic                  ph_consume_v_o,
  output logic                  pd_consume_v_o,
  output logic                  nph_consume_v_o,
  output logic                  npd_consume_v_o,
  output logic                  cplh_consume_v_o,
  output logic                  cpld_consume_v_o,
  output logic [PH_WIDTH-1:0]   ph_consume_dw_o,
  output logic [PD_WIDTH-1:0]   pd_consume_dw_o,
  output logic [NPH_WIDTH-1:0]  nph_consume_dw_o,
  output logic [NPD_WIDTH-1:0]  npd_consume_dw_o,
  output logic [CPLH_WIDTH-1:0] cplh_consume_dw_o,
  output logic [CPLD_WIDTH-1:0] cpld_consume_dw_o,

  output logic [DATA_W-1:0]     tx_data_o,
  output logic                  tx_valid_o,
  output logic                  tx_last_o,
  input  logic                  tx_ready_i,
  output logic [1:0]            tx_type_o,
  output logic                  busy_o
);

  localparam logic [1:0] G_P    = 2'd0;
  localparam logic [1:0] G_NP   = 2'd1;
  localparam logic [1:0] G_CPL  = 2'd2;
  localparam logic [1:0] G_NONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_XFER,
    S_SETTLE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [1:0] r_gnt;
  logic [1:0] r_rr;
  logic [1:0] w_win;
  logic       w_any;

  logic w_elig_p;
  logic w_elig_np;
  logic w_elig_cpl;

  logic              w_xfer;
  logic              w_src_v;
  logic              w_src_l;
  logic [DATA_W-1:0] w_src_d;
  logic              w_hs;

  logic                  r_ph_v;
  logic                  r_pd_v;
  logic                  r_nph_v;
  logic                  r_npd_v;
  logic                  r_cplh_v;
  logic                  r_cpld_v;
  logic [PH_WIDTH-1:0]   r_ph_dw;
  logic [PD_WIDTH-1:0]   r_pd_dw;
  logic [NPH_WIDTH-1:0]  r_nph_dw;
  logic [NPD_WIDTH-1:0]  r_npd_dw;
  logic [CPLH_WIDTH-1:0] r_cplh_dw;
  logic [CPLD_WIDTH-1:0] r_cpld_dw;

  // Zero data credit marks a header-only packet; data flag is ignored
  assign w_elig_p   = p_req_v_i & ph_credit_ok_i
                    & ((p_data_cr_i == '0) | pd_credit_ok_i);
  assign w_elig_np  = np_req_v_i & nph_credit_ok_i
                    & ((np_data_cr_i == '0) | npd_credit_ok_i);
  assign w_elig_cpl = cpl_req_v_i & cplh_credit_ok_i
                    & ((cpl_data_cr_i == '0) | cpld_credit_ok_i);

  assign w_any = w_elig_p | w_elig_np | w_elig_cpl;

  // Search starts at the requester after the last winner
  always_comb begin
    w_win = G_NONE;
    unique case (r_rr)
      G_P: begin
        if (w_elig_np)       w_win = G_NP;
        else if (w_elig_cpl) w_win = G_CPL;
        else if (w_elig_p)   w_win = G_P;
      end
      G_NP: begin
        if (w_elig_cpl)      w_win = G_CPL;
        else if (w_elig_p)   w_win = G_P;
        else if (w_elig_np)  w_win = G_NP;
      end
      default: begin
        if (w_elig_p)        w_win = G_P;
        else if (w_elig_np)  w_win = G_NP;
        else if (w_elig_cpl) w_win = G_CPL;
      end
    endcase
  end

  assign w_xfer = (r_state == S_XFER);

  always_comb begin
    w_src_v = 1'b0;
    w_src_l = 1'b0;
    w_src_d = '0;
    unique case (r_gnt)
      G_P: begin
        w_src_v = p_valid_i;
        w_src_l = p_last_i;
        w_src_d = p_data_i;
      end
      G_NP: begin
        w_src_v = np_valid_i;
        w_src_l = np_last_i;
        w_src_d = np_data_i;
      end
      G_CPL: begin
        w_src_v = cpl_valid_i;
        w_src_l = cpl_last_i;
        w_src_d = cpl_data_i;
      end
      default: ;
    endcase
  end

  assign tx_valid_o = w_xfer & w_src_v;
  assign tx_last_o  = w_xfer & w_src_l;
  assign tx_data_o  = w_xfer ? w_src_d : '0;
  assign w_hs       = tx_valid_o & tx_ready_i;

  assign p_ready_o   = w_xfer & (r_gnt == G_P)   & tx_ready_i;
  assign np_ready_o  = w_xfer & (r_gnt == G_NP)  & tx_ready_i;
  assign cpl_ready_o = w_xfer & (r_gnt == G_CPL) & tx_ready_i;

  assign tx_type_o = r_gnt;
  assign busy_o    = (r_state != S_IDLE);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_next = S_XFER;
      S_XFER:   if (w_hs && tx_last_o) w_next = S_SETTLE;
      S_SETTLE: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_gnt     <= G_NONE;
      r_rr      <= G_CPL;
      r_ph_v    <= 1'b0;
      r_pd_v    <= 1'b0;
      r_nph_v   <= 1'b0;
      r_npd_v   <= 1'b0;
      r_cplh_v  <= 1'b0;
      r_cpld_v  <= 1'b0;
      r_ph_dw   <= '0;
      r_pd_dw   <= '0;
      r_nph_dw  <= '0;
      r_npd_dw  <= '0;
      r_cplh_dw <= '0;
      r_cpld_dw <= '0;
    end else begin
      r_state  <= w_next;
      r_ph_v   <= 1'b0;
      r_pd_v   <= 1'b0;
      r_nph_v  <= 1'b0;
      r_npd_v  <= 1'b0;
      r_cplh_v <= 1'b0;
      r_cpld_v <= 1'b0;
      if (r_state == S_IDLE && w_any) begin
        r_gnt <= w_win;
        r_rr  <= w_win;
        // Pulses land in the first XFER cycle
        unique case (w_win)
          G_P: begin
            r_ph_v  <= 1'b1;
            r_ph_dw <= p_hdr_cr_i;
            r_pd_v  <= (p_data_cr_i != '0);
            r_pd_dw <= p_data_cr_i;
          end
          G_NP: begin
            r_nph_v  <= 1'b1;
            r_nph_dw <= np_hdr_cr_i;
            r_npd_v  <= (np_data_cr_i != '0);
            r_npd_dw <= np_data_cr_i;
          end
          G_CPL: begin
            r_cplh_v  <= 1'b1;
            r_cplh_dw <= cpl_hdr_cr_i;
            r_cpld_v  <= (cpl_data_cr_i != '0);
            r_cpld_dw <= cpl_data_cr_i;
          end
          default: ;
        endcase
      end
      if (w_xfer && w_hs && tx_last_o) begin
        r_gnt <= G_NONE;
      end
    end
  end

  assign ph_consume_v_o    = r_ph_v;
  assign pd_consume_v_o    = r_pd_v;
  assign nph_consume_v_o   = r_nph_v;
  assign npd_consume_v_o   = r_npd_v;
  assign cplh_consume_v_o  = r_cplh_v;
  assign cpld_consume_v_o  = r_cpld_v;
  assign ph_consume_dw_o   = r_ph_dw;
  assign pd_consume_dw_o   = r_pd_dw;
  assign nph_consume_dw_o  = r_nph_dw;
  assign npd_consume_dw_o  = r_npd_dw;
  assign cplh_consume_dw_o = r_cplh_dw;
  assign cpld_consume_dw_o = r_cpld_dw;

endmodule
